event_byte_sequencer: RTL and testbench
=======================================

Name: event_byte_sequencer

Overview:
- Accepts 64-bit logged-event words (timestamp plus input-state snapshot) over a valid/ready handshake.
- Streams each word out as 8 bytes over a byte-wide valid/ready port toward the host-interface FIFO.
- Contains a one-word active register, a one-word shadow buffer, a byte-index counter and the byte-select mux.
- Sits between the transition-capture logic and the host byte FIFO.

Parameters:
- LSB_FIRST, 1, 1: byte 0 = bits [7:0] sent first; 0: bits [63:56] sent first.
- CNT_W, 16, width of the sent-word statistics counter.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- in_word  input  64  event word.
- in_valid  input  1  in_word valid.
- in_ready  output  1  block can accept a word this cycle.
- out_byte  output  8  current byte.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  downstream accepts out_byte.
- out_first  output  1  out_byte is byte index 0 of a word.
- out_last  output  1  out_byte is byte index 7 of a word.
- byte_sel  output  3  current byte index; debug.
- busy  output  1  active or shadow register occupied.
- words_sent  output  CNT_W  count of fully transmitted words.

Behaviour:
- Reset (async assert, synchronous-release use assumed by system):
  - State EMPTY, byte_sel=0, out_valid=0, words_sent=0, active and shadow registers cleared.
  - in_ready=1 once reset_n is high.
- States:
  - EMPTY: no word held.
  - ACTIVE: active register held, shadow empty.
  - FULL: active and shadow both held.
- Outputs by state:
  - in_ready = (state != FULL); combinational from state only, no dependency on out_ready.
  - out_valid = (state != EMPTY).
  - busy = out_valid.
- Byte selection:
  - Bytes are taken from the active register.
  - Physical byte = byte_sel when LSB_FIRST=1, otherwise 7-byte_sel.
  - out_byte is combinational from active and byte_sel.
- Flags:
  - out_first = out_valid & (byte_sel==0).
  - out_last = out_valid & (byte_sel==7).
- Transfer definitions:
  - Accept = in_valid & in_ready.
  - Send = out_valid & out_ready.
  - Final = Send & (byte_sel==7).
- EMPTY:
  - Accept: load active, byte_sel=0, go to ACTIVE. Byte 0 appears the cycle after the accept (latency 1).
- ACTIVE:
  - Send & !Final: byte_sel+1.
  - Final & !Accept: byte_sel=0, words_sent+1, go to EMPTY.
  - Final & Accept: load in_word directly into active, byte_sel=0, words_sent+1, stay ACTIVE. No bubble.
  - !Final & Accept: load shadow, go to FULL.
- FULL:
  - in_ready=0, so no accept is possible.
  - Send & !Final: byte_sel+1.
  - Final: active<=shadow, byte_sel=0, words_sent+1, go to ACTIVE. The next word's byte 0 is valid the next cycle, so there is no bubble between words.
- Downstream stall:
  - out_ready low holds out_byte, byte_sel, out_first and out_last stable.
  - The output is never withdrawn while out_valid is high.
- Counters:
  - byte_sel is 3 bits and wraps 7->0 only on Final.
  - words_sent wraps modulo 2^CNT_W silently.
- Input timing: in_word is sampled only on Accept and may change freely otherwise.
- Reset mid-word: partial word discarded, no byte flushed, words_sent cleared, state EMPTY.
- Sustained throughput: 1 byte/cycle with out_ready held high; one word every 8 cycles.

Test Plan:
- Single word 0x8877665544332211, LSB_FIRST=1, out_ready=1 -> bytes 11,22,...,88 on 8 consecutive cycles starting 1 cycle after accept. out_first on 11, out_last on 88, words_sent=1, back to EMPTY.
- Same word, LSB_FIRST=0 -> bytes 88,77,...,11, flags on 88 and 11.
- Back-to-back words A then B, B offered while A is at byte 3 -> B enters shadow and in_ready drops. A's byte 7 is followed next cycle by B's byte 0. in_ready returns high the cycle after A's Final. words_sent=2.
- Random out_ready stalls, 30% low, over 100 random words -> scoreboard byte stream matches exactly, with no change of out_byte or the flags while stalled.
- Word offered on the same cycle as Final with shadow empty -> accepted directly into active, zero bubble, shadow never used.
- reset_n pulsed low at byte 5 of a word with shadow full -> out_valid=0 immediately, words_sent=0, in_ready=1. The next word starts at byte 0.

Source files
------------

// File: rtl/event_byte_sequencer_if.sv
// event_byte_sequencer_if: word-in / byte-out valid-ready handshake bundle.
interface event_byte_sequencer_if;
    logic [63:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_first, out_last
    );
    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_first, out_last
    );
endinterface

// File: rtl/event_byte_sequencer.sv
// event_byte_sequencer: serialises 64-bit event words into 8 bytes through an active/shadow pair.
module event_byte_sequencer #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    event_byte_sequencer_if.slave bus,
    output logic [2:0]            byte_sel,
    output logic                  busy,
    output logic [CNT_W-1:0]      words_sent
);
    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;
    state_t state, state_n;
    logic [63:0] active, active_n, shadow, shadow_n;
    logic [2:0] sel_n, phys;
    logic [CNT_W-1:0] ws_n;
    logic accept, send, fin;
    assign bus.in_ready  = state != FULL;
    assign bus.out_valid = state != EMPTY;
    assign busy          = bus.out_valid;
    assign accept        = bus.in_valid & bus.in_ready;
    assign send          = bus.out_valid & bus.out_ready;
    assign fin           = send & (byte_sel == 3'd7);
    assign phys          = LSB_FIRST ? byte_sel : 3'd7 - byte_sel;
    assign bus.out_byte  = active[{phys, 3'b000} +: 8];
    assign bus.out_first = bus.out_valid & (byte_sel == 3'd0);
    assign bus.out_last  = bus.out_valid & (byte_sel == 3'd7);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            active     <= '0;
            shadow     <= '0;
            byte_sel   <= '0;
            words_sent <= '0;
        end else begin
            state      <= state_n;
            active     <= active_n;
            shadow     <= shadow_n;
            byte_sel   <= sel_n;
            words_sent <= ws_n;
        end
    end
    // A Final always restarts the index; a word arriving on that same cycle skips the shadow
    always_comb begin
        state_n  = state;
        active_n = active;
        shadow_n = shadow;
        sel_n    = fin ? 3'd0 : send ? byte_sel + 3'd1 : byte_sel;
        ws_n     = fin ? words_sent + CNT_W'(1) : words_sent;
        case (state)
            EMPTY: begin
                if (accept) begin
                    active_n = bus.in_word;
                    state_n  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (fin && accept) active_n = bus.in_word;
                else if (fin) state_n = EMPTY;
                else if (accept) begin
                    shadow_n = bus.in_word;
                    state_n  = FULL;
                end
            end
            FULL: begin
                if (fin) begin
                    active_n = shadow;
                    state_n  = ACTIVE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end
endmodule

// File: tb/tb_event_byte_sequencer.sv
// tb_event_byte_sequencer: directed and stalled-stream checks for both byte orders.
module tb_event_byte_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    logic [2:0] sel, sel_m;
    logic busy, busy_m;
    logic [15:0] ws, ws_m;
    int errors = 0;
    int checks = 0;
    int ws_exp = 0;

    event_byte_sequencer_if bi();
    event_byte_sequencer_if bm();

    event_byte_sequencer #(.LSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bi), .byte_sel(sel), .busy(busy), .words_sent(ws)
    );
    event_byte_sequencer #(.LSB_FIRST(1'b0), .CNT_W(16)) dut_m (
        .clk(clk), .reset_n(reset_n), .bus(bm), .byte_sel(sel_m), .busy(busy_m), .words_sent(ws_m)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bi.in_valid = 1'b0; bi.in_word = '0; bi.out_ready = 1'b1;
        bm.in_valid = 1'b0; bm.in_word = '0; bm.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bi.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bi.out_valid); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bi.in_ready); end
        checks++; if (ws !== 16'd0) begin errors++; $display("FAIL rst_words_sent got=%0d exp=0", ws); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_byte_sel got=%0d exp=0", sel); end
        checks++; if (busy !== 1'b0 || bi.out_first !== 1'b0 || bi.out_last !== 1'b0) begin
            errors++; $display("FAIL rst_flags got busy=%b first=%b last=%b exp=0,0,0", busy, bi.out_first, bi.out_last);
        end
    endtask

    task automatic test_single_lsb();
        logic [7:0] e;
        bi.in_word = 64'h8877665544332211; bi.in_valid = 1'b1;
        cyc();
        bi.in_valid = 1'b0; bi.in_word = 64'hDEADBEEFDEADBEEF;
        for (int i = 0; i < 8; i++) begin
            e = 8'(17 * (i + 1));
            checks++; if (bi.out_valid !== 1'b1 || bi.out_byte !== e) begin
                errors++; $display("FAIL lsb_byte%0d got=%h v=%b exp=%h v=1", i, bi.out_byte, bi.out_valid, e);
            end
            checks++; if (bi.out_first !== (i == 0) || bi.out_last !== (i == 7)) begin
                errors++; $display("FAIL lsb_flags%0d got first=%b last=%b exp %b %b", i, bi.out_first, bi.out_last, i == 0, i == 7);
            end
            cyc();
        end
        ws_exp += 1;
        checks++; if (bi.out_valid !== 1'b0 || bi.in_ready !== 1'b1) begin
            errors++; $display("FAIL lsb_empty got v=%b rdy=%b exp v=0 rdy=1", bi.out_valid, bi.in_ready);
        end
        checks++; if (ws !== 16'(ws_exp)) begin errors++; $display("FAIL lsb_words got=%0d exp=%0d", ws, ws_exp); end
    endtask

    task automatic test_single_msb();
        logic [7:0] e;
        bm.in_word = 64'h8877665544332211; bm.in_valid = 1'b1;
        cyc();
        bm.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = 8'(17 * (8 - i));
            checks++; if (bm.out_valid !== 1'b1 || bm.out_byte !== e) begin
                errors++; $display("FAIL msb_byte%0d got=%h v=%b exp=%h v=1", i, bm.out_byte, bm.out_valid, e);
            end
            checks++; if (bm.out_first !== (i == 0) || bm.out_last !== (i == 7)) begin
                errors++; $display("FAIL msb_flags%0d got first=%b last=%b exp %b %b", i, bm.out_first, bm.out_last, i == 0, i == 7);
            end
            cyc();
        end
        checks++; if (bm.out_valid !== 1'b0 || ws_m !== 16'd1) begin
            errors++; $display("FAIL msb_done got v=%b words=%0d exp v=0 words=1", bm.out_valid, ws_m);
        end
    endtask

    task automatic test_back_to_back();
        bi.in_word = 64'hA7A6A5A4A3A2A1A0; bi.in_valid = 1'b1;
        cyc();
        bi.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bi.out_byte !== 8'(8'hA0 + i)) begin errors++; $display("FAIL b2b_a%0d got=%h exp=%h", i, bi.out_byte, 8'(8'hA0 + i)); end
            if (i == 3) begin
                checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy_before got=%b exp=1", bi.in_ready); end
                bi.in_word = 64'hB7B6B5B4B3B2B1B0; bi.in_valid = 1'b1;
            end
            if (i >= 4) begin
                checks++; if (bi.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full%0d got=%b exp=0", i, bi.in_ready); end
            end
            cyc();
            bi.in_valid = 1'b0; bi.in_word = 64'h0123456789ABCDEF;
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bi.out_valid !== 1'b1 || bi.out_byte !== 8'(8'hB0 + i)) begin
                errors++; $display("FAIL b2b_b%0d got=%h v=%b exp=%h v=1", i, bi.out_byte, bi.out_valid, 8'(8'hB0 + i));
            end
            if (i == 0) begin
                checks++; if (bi.in_ready !== 1'b1 || bi.out_first !== 1'b1) begin
                    errors++; $display("FAIL b2b_b_start got rdy=%b first=%b exp 1 1", bi.in_ready, bi.out_first);
                end
            end
            cyc();
        end
        ws_exp += 2;
        checks++; if (ws !== 16'(ws_exp) || bi.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_done got words=%0d v=%b exp words=%0d v=0", ws, bi.out_valid, ws_exp);
        end
    endtask

    task automatic test_same_cycle_final();
        bi.in_word = 64'hC7C6C5C4C3C2C1C0; bi.in_valid = 1'b1;
        cyc();
        bi.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bi.out_byte !== 8'(8'hC0 + i)) begin errors++; $display("FAIL scf_c%0d got=%h exp=%h", i, bi.out_byte, 8'(8'hC0 + i)); end
            if (i == 7) begin
                checks++; if (bi.in_ready !== 1'b1) begin errors++; $display("FAIL scf_rdy_at_final got=%b exp=1", bi.in_ready); end
                bi.in_word = 64'hD7D6D5D4D3D2D1D0; bi.in_valid = 1'b1;
            end
            cyc();
            bi.in_valid = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bi.out_valid !== 1'b1 || bi.out_byte !== 8'(8'hD0 + i) || bi.in_ready !== 1'b1) begin
                errors++; $display("FAIL scf_d%0d got=%h v=%b rdy=%b exp=%h v=1 rdy=1", i, bi.out_byte, bi.out_valid, bi.in_ready, 8'(8'hD0 + i));
            end
            cyc();
        end
        ws_exp += 2;
        checks++; if (ws !== 16'(ws_exp) || bi.out_valid !== 1'b0) begin
            errors++; $display("FAIL scf_done got words=%0d v=%b exp words=%0d v=0", ws, bi.out_valid, ws_exp);
        end
    endtask

    task automatic test_stall_random();
        logic [10:0] q[$];
        logic [10:0] e;
        logic [63:0] w;
        logic [7:0] pb;
        logic pf, pl;
        logic pstall = 1'b0;
        int sent = 0;
        int n = 0;
        while ((sent < 100 || q.size() != 0) && n < 5000) begin
            if (pstall) begin
                checks++; if (bi.out_byte !== pb || bi.out_first !== pf || bi.out_last !== pl) begin
                    errors++; $display("FAIL stall_hold got=%h %b %b exp=%h %b %b", bi.out_byte, bi.out_first, bi.out_last, pb, pf, pl);
                end
            end
            bi.out_ready = ($urandom_range(0, 9) >= 3);
            bi.in_valid = (sent < 100) && ($urandom_range(0, 1) == 1);
            w = {$urandom(), $urandom()};
            bi.in_word = w;
            if (bi.out_valid && bi.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stall_extra got=%h exp=none", bi.out_byte);
                end else begin
                    e = q.pop_front();
                    if (bi.out_byte !== e[7:0] || bi.out_first !== (e[10:8] == 3'd0) || bi.out_last !== (e[10:8] == 3'd7)) begin
                        errors++; $display("FAIL stall_byte got=%h %b %b exp=%h idx=%0d", bi.out_byte, bi.out_first, bi.out_last, e[7:0], e[10:8]);
                    end
                end
            end
            if (bi.in_valid && bi.in_ready) begin
                sent++;
                for (int k = 0; k < 8; k++) q.push_back({3'(k), w[8*k +: 8]});
            end
            pstall = bi.out_valid && !bi.out_ready;
            pb = bi.out_byte; pf = bi.out_first; pl = bi.out_last;
            cyc();
            n++;
        end
        bi.in_valid = 1'b0; bi.out_ready = 1'b1;
        ws_exp += 100;
        checks++; if (n >= 5000) begin errors++; $display("FAIL stall_timeout got cycles=%0d exp<5000", n); end
        checks++; if (ws !== 16'(ws_exp) || bi.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_words got=%0d v=%b exp=%0d v=0", ws, bi.out_valid, ws_exp);
        end
    endtask

    task automatic test_reset_mid();
        bi.in_word = 64'hE7E6E5E4E3E2E1E0; bi.in_valid = 1'b1;
        cyc();
        bi.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin bi.in_word = 64'hF7F6F5F4F3F2F1F0; bi.in_valid = 1'b1; end
            cyc();
            bi.in_valid = 1'b0;
        end
        checks++; if (sel !== 3'd5 || bi.in_ready !== 1'b0 || bi.out_byte !== 8'hE5) begin
            errors++; $display("FAIL rmid_pre got sel=%0d rdy=%b byte=%h exp 5 0 e5", sel, bi.in_ready, bi.out_byte);
        end
        reset_n = 1'b0;
        #1;
        checks++; if (bi.out_valid !== 1'b0 || ws !== 16'd0 || bi.in_ready !== 1'b1 || sel !== 3'd0) begin
            errors++; $display("FAIL rmid_reset got v=%b words=%0d rdy=%b sel=%0d exp 0 0 1 0", bi.out_valid, ws, bi.in_ready, sel);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ws_exp = 0;
        bi.in_word = 64'h1716151413121110; bi.in_valid = 1'b1;
        cyc();
        bi.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bi.out_byte !== 8'(8'h10 + i) || sel !== 3'(i) || bi.out_valid !== 1'b1) begin
                errors++; $display("FAIL rmid_g%0d got=%h sel=%0d v=%b exp=%h sel=%0d v=1", i, bi.out_byte, sel, bi.out_valid, 8'(8'h10 + i), i);
            end
            cyc();
        end
        checks++; if (ws !== 16'd1 || bi.out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_done got words=%0d v=%b exp words=1 v=0", ws, bi.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_lsb();
        test_single_msb();
        test_back_to_back();
        test_same_cycle_final();
        test_stall_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
